// File: rtl/spi_ram_responder.sv
// SPI mode-0 RAM responder: 0x02 write / 0x03 read with an ADDR_BITS address
// phase, sequential wrap-around bursts and a backdoor read port for benches.
`timescale 1ns/1ps
module spi_ram_responder #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_select,
    input  logic                         spi_clk,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    output logic                         busy,
    output logic                         cmd_error,
    input  logic [$clog2(MEM_BYTES)-1:0] dbg_addr,
    output logic [7:0]                   dbg_data
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    localparam int unsigned CW = (ADDR_BITS > 1) ? $clog2(ADDR_BITS) : 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

    state_t          state, nxt;
    logic            sclk_q;
    logic            rise, fall;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   addr_cnt;
    logic [7:0]      shift;
    logic [7:0]      byte_in;
    logic [7:0]      rd_sh;
    logic [AW-1:0]   addr;
    logic            is_read;
    logic            load_pending;
    logic            armed;
    logic            miso;
    logic            bit_done;
    logic            addr_done;
    logic            wr_en;
    logic            cmd_bad;
    logic [7:0]      mem [MEM_BYTES];

    assign rise      = spi_clk & ~sclk_q;
    assign fall      = ~spi_clk & sclk_q;
    assign byte_in   = {shift[6:0], spi_mosi};
    assign bit_done  = rise && (bit_cnt == 3'd7);
    assign addr_done = rise && (addr_cnt == CW'(ADDR_BITS - 1));
    assign busy      = ~spi_select && (state != IDLE);
    assign spi_miso  = miso;
    assign dbg_data  = mem[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt     = state;
        wr_en   = 1'b0;
        cmd_bad = 1'b0;
        if (spi_select) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (armed) nxt = CMD;
                CMD: begin
                    if (bit_done) begin
                        if (byte_in == 8'h03 || byte_in == 8'h02) begin
                            nxt = ADDR;
                        end else begin
                            nxt     = IGNORE;
                            cmd_bad = 1'b1;
                        end
                    end
                end
                ADDR:  if (addr_done) nxt = is_read ? READ : WRITE;
                WRITE: wr_en = bit_done;
                default: nxt = state;
            endcase
        end
    end

    // armed stays low after reset until the master deselects once, so a
    // transaction cut by reset cannot be resumed mid-stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q       <= 1'b0;
            bit_cnt      <= '0;
            addr_cnt     <= '0;
            shift        <= '0;
            rd_sh        <= '0;
            addr         <= '0;
            is_read      <= 1'b0;
            load_pending <= 1'b0;
            armed        <= 1'b0;
            miso         <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            sclk_q    <= spi_clk;
            cmd_error <= cmd_bad;
            armed     <= armed | spi_select;
            if (spi_select) begin
                miso         <= 1'b0;
                load_pending <= 1'b0;
            end else begin
                if (state != READ) miso <= 1'b0;
                case (state)
                    IDLE: begin
                        bit_cnt      <= '0;
                        addr_cnt     <= '0;
                        shift        <= '0;
                        load_pending <= 1'b0;
                    end
                    CMD: begin
                        if (rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (bit_done) begin
                            is_read  <= (byte_in == 8'h03);
                            addr_cnt <= '0;
                            addr     <= '0;
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr     <= AW'({addr, spi_mosi});
                            addr_cnt <= addr_cnt + CW'(1);
                        end
                        if (addr_done) begin
                            bit_cnt      <= '0;
                            shift        <= '0;
                            load_pending <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (rise) begin
                            shift   <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        if (bit_done) addr <= addr + AW'(1);
                    end
                    READ: begin
                        if (rise) bit_cnt <= bit_cnt + 3'd1;
                        if (bit_done) begin
                            addr         <= addr + AW'(1);
                            load_pending <= 1'b1;
                        end
                        // A byte boundary loads the freshly addressed byte on
                        // the fall; otherwise the next bit shifts out.
                        if (fall) begin
                            if (load_pending) begin
                                miso         <= mem[addr][7];
                                rd_sh        <= {mem[addr][6:0], 1'b0};
                                load_pending <= 1'b0;
                            end else begin
                                miso  <= rd_sh[7];
                                rd_sh <= {rd_sh[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[addr] <= byte_in;
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed and randomized checks of spi_ram_responder against a byte-array
// reference memory updated only by fully transferred write bytes.
`timescale 1ns/1ps
module tb_spi_ram_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_select = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       busy;
    logic       cmd_error;
    logic [7:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    int         n_assert = 0;
    int         n_fail = 0;
    int         ph = 2;
    logic [7:0] ref_mem [256];
    logic [7:0] q [$];
    int         err_cycles = 0;
    int         err_pulses = 0;
    logic       err_prev = 1'b0;

    spi_ram_responder #(.ADDR_BITS(16), .MEM_BYTES(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_select (spi_select),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .busy       (busy),
        .cmd_error  (cmd_error),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_error) err_cycles++;
        if (cmd_error && !err_prev) err_pulses++;
        err_prev = cmd_error;
    end

    initial begin
        #900us;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic r);
        spi_mosi = b;
        wait_clk(ph);
        r = spi_miso;
        spi_clk = 1'b1;
        wait_clk(ph);
        spi_clk = 1'b0;
    endtask

    task automatic xfer_byte(input logic [7:0] b, output logic [7:0] r);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(b[i], x);
            r[i] = x;
        end
    endtask

    task automatic cs_low(input logic exp_busy);
        spi_select = 1'b0;
        wait_clk(2);
        check("busy_after_select", busy, exp_busy);
    endtask

    task automatic cs_high();
        wait_clk(ph);
        spi_select = 1'b1;
        spi_mosi   = 1'b0;
        wait_clk(2);
        check("busy_after_deselect", busy, 1'b0);
    endtask

    task automatic header(input logic [7:0] cmd, input logic [15:0] a);
        logic [7:0] r;
        xfer_byte(cmd, r);
        xfer_byte(a[15:8], r);
        xfer_byte(a[7:0], r);
    endtask

    task automatic do_write(input logic [15:0] a, input int extra_bits);
        logic x;
        cs_low(1'b1);
        header(8'h02, a);
        for (int i = 0; i < q.size(); i++) begin
            logic [7:0] r;
            xfer_byte(q[i], r);
            ref_mem[(int'(a) + i) % 256] = q[i];
        end
        for (int i = 0; i < extra_bits; i++) xfer_bit(1'($urandom), x);
        cs_high();
    endtask

    task automatic do_read(input logic [15:0] a, input int n, input string tag);
        logic [7:0] r;
        cs_low(1'b1);
        header(8'h03, a);
        for (int i = 0; i < n; i++) begin
            xfer_byte(8'h00, r);
            check(tag, r, ref_mem[(int'(a) + i) % 256]);
        end
        cs_high();
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++) begin
            dbg_addr = 8'(i);
            #1;
            check(tag, dbg_data, ref_mem[i]);
        end
    endtask

    task automatic peek(input logic [7:0] a, input logic [7:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        logic [7:0] r;
        logic       x;
        logic       miso_or;
        int         e0, c0;
        logic [15:0] ra;

        // reset with select held low
        spi_select = 1'b0;
        wait_clk(3);
        check("reset_busy", busy, 1'b0);
        check("reset_miso", spi_miso, 1'b0);
        check("reset_cmd_error", cmd_error, 1'b0);

        // released while selected: traffic ignored until a deselect
        rst_n = 1'b1;
        wait_clk(2);
        xfer_byte(8'h02, r);
        xfer_byte(8'h9F, r);
        check("unarmed_busy", busy, 1'b0);
        check("unarmed_miso", r, 8'h00);
        check("unarmed_cmd_error", err_pulses, 0);
        cs_high();

        // fill the whole array so every location is known
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        ph = 1;
        do_write(16'h0000, 0);
        ph = 2;
        check_mem("fill");

        // basic two-byte write then read back
        q = '{8'hAB, 8'hCD};
        do_write(16'h0010, 0);
        peek(8'h10, 8'hAB, "wr_0x10");
        peek(8'h11, 8'hCD, "wr_0x11");
        check("no_cmd_error", err_pulses, 0);
        do_read(16'h0010, 2, "rd_0x10");

        // wrap-around write and read
        q = '{8'h11, 8'h22};
        do_write(16'h00FF, 0);
        peek(8'hFF, 8'h11, "wrap_wr_ff");
        peek(8'h00, 8'h22, "wrap_wr_00");
        do_read(16'h00FF, 2, "wrap_rd");

        // unsupported command
        e0 = err_pulses;
        c0 = err_cycles;
        cs_low(1'b1);
        xfer_byte(8'h9F, r);
        miso_or = |r;
        for (int i = 0; i < 3; i++) begin
            xfer_byte(8'($urandom), r);
            miso_or = miso_or | (|r);
        end
        check("bad_cmd_pulses", err_pulses - e0, 1);
        check("bad_cmd_cycles", err_cycles - c0, 1);
        check("bad_cmd_miso", miso_or, 1'b0);
        check("bad_cmd_busy", busy, 1'b1);
        cs_high();
        check_mem("bad_cmd_mem");

        // partial write byte is discarded, then a full one lands
        cs_low(1'b1);
        header(8'h02, 16'h0005);
        for (int i = 0; i < 5; i++) xfer_bit(1'b1, x);
        cs_high();
        peek(8'h05, ref_mem[5], "partial_write");
        q = '{8'h5C};
        do_write(16'h0005, 0);
        peek(8'h05, 8'h5C, "after_partial");

        // deselect coincident with the 8th data rise wins
        cs_low(1'b1);
        header(8'h02, 16'h0040);
        for (int i = 0; i < 7; i++) xfer_bit(~ref_mem[8'h40][7 - i], x);
        spi_mosi = ~ref_mem[8'h40][0];
        wait_clk(ph);
        spi_clk    = 1'b1;
        spi_select = 1'b1;
        wait_clk(2);
        spi_clk = 1'b0;
        wait_clk(2);
        check("race_busy", busy, 1'b0);
        peek(8'h40, ref_mem[8'h40], "race_no_write");

        // reset in the middle of a write byte
        cs_low(1'b1);
        header(8'h02, 16'h0020);
        xfer_byte(8'h5A, r);
        ref_mem[8'h20] = 8'h5A;
        for (int i = 0; i < 4; i++) xfer_bit(1'b1, x);
        rst_n = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(1);
        cs_high();
        check_mem("reset_mid_write");

        // reset in the middle of a read
        cs_low(1'b1);
        header(8'h03, 16'h0080);
        xfer_byte(8'h00, r);
        check("pre_reset_rd", r, ref_mem[8'h80]);
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, x);
        rst_n = 1'b0;
        wait_clk(1);
        check("reset_rd_miso", spi_miso, 1'b0);
        check("reset_rd_busy", busy, 1'b0);
        wait_clk(1);
        rst_n = 1'b1;
        wait_clk(2);
        check("post_reset_busy", busy, 1'b0);
        cs_high();
        check_mem("reset_mid_read");
        do_read(16'h0080, 3, "rd_after_reset");

        // randomized transactions with varied phase lengths
        for (int t = 0; t < 24; t++) begin
            ph = int'($urandom_range(1, 3));
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                q.delete();
                for (int i = 0; i < int'($urandom_range(1, 5)); i++) q.push_back(8'($urandom));
                do_write(ra, int'($urandom_range(0, 7)));
            end else begin
                do_read(ra, int'($urandom_range(1, 5)), "rand_rd");
            end
        end
        ph = 2;
        check_mem("final_mem");
        check("final_no_extra_err", err_pulses, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
